// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch-stage icache request interface.
// Latency: response strobe LATENCY cycles after acceptance (LATENCY..LATENCY+3 with IMEM_RANDOM_STALL_EN).
// Backpressure: single outstanding request; req_ready_o is high only in IDLE; kill_i drops the pending request.
module imem_responder #(
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'h200,
  parameter int                    LATENCY    = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_valid_i,
  input  logic [ADDR_WIDTH-1:0]    req_vaddr_i,
  input  logic                     kill_i,
  output logic                     req_ready_o,
  output logic                     resp_valid_o,
  output logic [31:0]              resp_data_o,
  output logic                     resp_misaligned_o,
  output logic                     resp_access_fault_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [31:0]              wr_data_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 5;
  // One past the last valid byte address, one bit wider so it cannot overflow.
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + ((ADDR_WIDTH+1)'(DEPTH) << 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;        // WAIT cycles still to spend
  logic [CNT_W-1:0]      wait_load;  // WAIT cycles for a newly accepted request
  logic [ADDR_WIDTH-1:0] vaddr_q;
  logic [IDX_W+1:0]      offset;
  logic [IDX_W-1:0]      rd_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  unused_offset_bits;
  logic [31:0]           mem [DEPTH];

  assign req_ready_o = (state == S_IDLE);

  // Only the low bits of (vaddr - BASE_ADDR) matter for the index; the range
  // check is a plain unsigned compare on the full address, so nothing wraps.
  assign offset             = vaddr_q[IDX_W+1:0] - BASE_ADDR[IDX_W+1:0];
  assign rd_idx             = offset[IDX_W+1:2];
  assign unused_offset_bits = ^offset[1:0];
  assign misaligned         = |vaddr_q[1:0];
  assign out_of_range       = (vaddr_q < BASE_ADDR) || ({1'b0, vaddr_q} >= END_ADDR);

`ifdef IMEM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying 0-3 extra stall cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign wait_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign wait_load = CNT_W'(LATENCY - 1);
`endif

  // Preload port: writes land in any state; memory contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
  end

  // Request FSM with registered response outputs; the array is read on the RESP
  // edge, so a write on that same edge is not yet visible to the response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      vaddr_q             <= '0;
      resp_valid_o        <= 1'b0;
      resp_data_o         <= '0;
      resp_misaligned_o   <= 1'b0;
      resp_access_fault_o <= 1'b0;
    end else begin
      // Response fields are only non-zero during the single strobe cycle.
      resp_valid_o        <= 1'b0;
      resp_data_o         <= '0;
      resp_misaligned_o   <= 1'b0;
      resp_access_fault_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i && !kill_i) begin
            vaddr_q <= req_vaddr_i;
            cnt     <= wait_load;
            state   <= (wait_load == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (!kill_i) begin
            resp_valid_o        <= 1'b1;
            resp_misaligned_o   <= misaligned;
            resp_access_fault_o <= !misaligned && out_of_range;
            resp_data_o         <= (misaligned || out_of_range) ? 32'h0 : mem[rd_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (default build: fixed latency).
// Reference model tracks one outstanding request by cycle number and a shadow memory.
// Random requests, kills and preload writes, plus directed fetch/fault/kill/reset cases.
module tb_imem_responder;
  localparam int          AW    = 40;
  localparam int          DEPTH = 1024;
  localparam int          IW    = 10;
  localparam int          LAT   = 2;
  localparam logic [39:0] BASE  = 40'h200;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          req_valid_i;
  logic [AW-1:0] req_vaddr_i;
  logic          kill_i;
  logic          req_ready_o;
  logic          resp_valid_o;
  logic [31:0]   resp_data_o;
  logic          resp_misaligned_o;
  logic          resp_access_fault_o;
  logic          wr_en_i;
  logic [IW-1:0] wr_idx_i;
  logic [31:0]   wr_data_i;

  always #5 clk_i = ~clk_i;

  imem_responder #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .kill_i(kill_i),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_misaligned_o(resp_misaligned_o), .resp_access_fault_o(resp_access_fault_o),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] shadow [DEPTH];
  bit          pend;
  longint      acc_cyc;
  logic [39:0] pend_va;
  longint      cyc;
  bit          exp_vld;
  logic [31:0] exp_dat;
  bit          exp_mis;
  bit          exp_af;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected response for an address, reading the shadow memory as it is now.
  function automatic void model_resp(input logic [39:0] va);
    bit mis;
    bit oor;
    logic [39:0] off;
    mis = (va[1:0] != 2'b00);
    oor = (va < BASE) || (va >= BASE + 40'(4 * DEPTH));
    off = (va - BASE) >> 2;
    exp_vld = 1'b1;
    exp_mis = mis;
    exp_af  = !mis && oor;
    exp_dat = (mis || oor) ? 32'h0 : shadow[off[IW-1:0]];
  endfunction

  // One clock cycle: check current outputs, drive inputs, advance the model to the next edge.
  task automatic step(input bit v, input logic [39:0] va, input bit k,
                      input bit we, input logic [IW-1:0] wi, input logic [31:0] wd);
    bit rdy_now;
    @(negedge clk_i);
    check("req_ready",    64'(req_ready_o),         64'(!pend));
    check("resp_valid",   64'(resp_valid_o),        64'(exp_vld));
    check("resp_data",    64'(resp_data_o),         64'(exp_vld ? exp_dat : 32'h0));
    check("resp_misalgn", 64'(resp_misaligned_o),   64'(exp_vld && exp_mis));
    check("resp_afault",  64'(resp_access_fault_o), 64'(exp_vld && exp_af));
    req_valid_i = v;
    req_vaddr_i = va;
    kill_i      = k;
    wr_en_i     = we;
    wr_idx_i    = wi;
    wr_data_i   = wd;
    rdy_now = !pend;
    exp_vld = 1'b0;
    exp_dat = '0;
    exp_mis = 1'b0;
    exp_af  = 1'b0;
    if (pend && k) begin
      pend = 1'b0;
    end else if (pend && (cyc + 1 == acc_cyc + LAT)) begin
      model_resp(pend_va);
      pend = 1'b0;
    end
    if (we) shadow[wi] = wd;
    if (rdy_now && v && !k) begin
      pend    = 1'b1;
      acc_cyc = cyc + 1;
      pend_va = va;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 40'h0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  function automatic logic [39:0] rand_va();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return BASE - 40'(4 * $urandom_range(1, 3));
      1:       return BASE + 40'(4 * DEPTH) + 40'(4 * $urandom_range(0, 1));
      2:       return BASE + 40'(4 * DEPTH - 4);
      3:       return BASE + 40'($urandom_range(0, 63));
      4:       return {8'($urandom), 32'($urandom)};
      5, 6:    return BASE + 40'(4 * $urandom_range(0, DEPTH - 1));
      default: return BASE + 40'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    rstn_i = 1'b0; req_valid_i = 1'b0; req_vaddr_i = '0; kill_i = 1'b0;
    wr_en_i = 1'b0; wr_idx_i = '0; wr_data_i = '0;
    pend = 1'b0; acc_cyc = 0; pend_va = '0; cyc = 0;
    exp_vld = 1'b0; exp_dat = '0; exp_mis = 1'b0; exp_af = 1'b0;

    #12;
    check("rst_ready",  64'(req_ready_o),         64'(1));
    check("rst_valid",  64'(resp_valid_o),        64'(0));
    check("rst_data",   64'(resp_data_o),         64'(0));
    check("rst_misalg", 64'(resp_misaligned_o),   64'(0));
    check("rst_afault", 64'(resp_access_fault_o), 64'(0));
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Preload the whole array with random words
    for (int i = 0; i < DEPTH; i++) step(1'b0, 40'h0, 1'b0, 1'b1, IW'(i), $urandom);

    // Basic fetch of word 0
    step(1'b0, 40'h0, 1'b0, 1'b1, IW'(0), 32'h00500013);
    step(1'b1, 40'h200, 1'b0, 1'b0, '0, 32'h0);
    idle(4);

    // Back-to-back with req_valid held high
    for (int i = 0; i < 6; i++) step(1'b1, (i < 3) ? 40'h204 : 40'h208, 1'b0, 1'b0, '0, 32'h0);
    idle(4);

    // Misaligned, then both sides of the address window
    step(1'b1, 40'h202, 1'b0, 1'b0, '0, 32'h0);
    idle(4);
    step(1'b1, 40'h1FC, 1'b0, 1'b0, '0, 32'h0);
    idle(4);
    step(1'b1, BASE + 40'(4 * DEPTH), 1'b0, 1'b0, '0, 32'h0);
    idle(4);
    step(1'b1, BASE + 40'(4 * DEPTH - 4), 1'b0, 1'b0, '0, 32'h0);
    idle(4);

    // Kill one cycle after acceptance, then fetch idx 3 in the next IDLE cycle
    step(1'b1, 40'h200, 1'b0, 1'b0, '0, 32'h0);
    step(1'b0, 40'h0, 1'b1, 1'b0, '0, 32'h0);
    step(1'b1, 40'h20C, 1'b0, 1'b0, '0, 32'h0);
    idle(4);

    // Write to the pending index while waiting; newer data must be returned
    step(1'b1, 40'h210, 1'b0, 1'b0, '0, 32'h0);
    step(1'b0, 40'h0, 1'b0, 1'b1, IW'(4), 32'hCAFEF00D);
    idle(4);

    // Reset asserted during WAIT
    step(1'b1, 40'h200, 1'b0, 1'b0, '0, 32'h0);
    idle(1);
    rstn_i = 1'b0;
    #1;
    check("midrst_valid",  64'(resp_valid_o),        64'(0));
    check("midrst_data",   64'(resp_data_o),         64'(0));
    check("midrst_misalg", 64'(resp_misaligned_o),   64'(0));
    check("midrst_afault", 64'(resp_access_fault_o), 64'(0));
    check("midrst_ready",  64'(req_ready_o),         64'(1));
    req_valid_i = 1'b0; kill_i = 1'b0; wr_en_i = 1'b0;
    @(negedge clk_i);
    rstn_i  = 1'b1;
    pend    = 1'b0;
    exp_vld = 1'b0;
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) != 0), rand_va(), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) == 0), IW'($urandom_range(0, 15)), $urandom);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
